// File: rtl/imm_decode_pkg.sv
// Shared definitions for the immediate-decode stage: format codes, RV opcodes
// and small helpers used at elaboration and decode time.
package imm_decode_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Only PC-relative control transfers carry a precomputed target.
    function automatic bit fmt_has_target(input logic [2:0] fmt);
        return (fmt == FMT_B) || (fmt == FMT_J);
    endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Purely combinational RV immediate extractor: instruction word in,
// sign/zero-extended immediate, format code and illegal flag out.
module imm_decode_core
    import imm_decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit ENABLE_RV64_W = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit W_OK = ENABLE_RV64_W && (XLEN == 64);

    logic [6:0]  opcode;
    logic [31:0] imm32;
    fmt_e        fmt_sel;

    assign opcode = instr[6:0];

    always_comb begin
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt_sel = FMT_I;
            OPC_OP_IMM_32: begin
                if (W_OK) begin
                    fmt_sel = FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE:          fmt_sel = FMT_S;
            OPC_BRANCH:         fmt_sel = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt_sel = FMT_U;
            OPC_JAL:            fmt_sel = FMT_J;
            OPC_SYSTEM: begin
                // Only the CSR*I forms (funct3[2]=1) carry a uimm.
                if (instr[14]) begin
                    fmt_sel = FMT_Z;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Every format fits a signed 32-bit value; widening happens once below.
    always_comb begin
        imm32 = '0;
        case (fmt_sel)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, instr[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));
    assign fmt = fmt_sel;

endmodule

// File: rtl/imm_decode_stage.sv
// Pipeline stage that decodes the immediate before registering and buffers
// results in a two-entry (output + skid) FIFO with a registered in_ready.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit ENABLE_RV64_W = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;

    entry_t out_entry_reg;
    entry_t skid_entry_reg;
    logic   out_valid_reg, out_valid_next;
    logic   skid_valid_reg, skid_valid_next;
    logic   in_ready_reg, in_ready_next;

    logic push, pop;
    logic load_out_from_in, load_out_from_skid, load_skid;

    imm_decode_core #(
        .XLEN          (XLEN),
        .ENABLE_RV64_W (ENABLE_RV64_W)
    ) u_core (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_entry.instr   = in_instr;
        dec_entry.pc      = in_pc;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
        dec_entry.target  = fmt_has_target(dec_fmt) ? (in_pc + dec_imm) : '0;
    end

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid_reg && out_ready;

    // in_ready_reg is low whenever the skid holds data, so a push never
    // coincides with a full skid; flush overrides every movement.
    assign load_out_from_skid = !flush && pop && skid_valid_reg;
    assign load_out_from_in   = !flush && push && (!out_valid_reg || (pop && !skid_valid_reg));
    assign load_skid          = !flush && push && out_valid_reg && !pop;

    always_comb begin
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (load_out_from_in || load_out_from_skid) begin
                out_valid_next = 1'b1;
            end else if (pop) begin
                out_valid_next = 1'b0;
            end
            if (load_skid) begin
                skid_valid_next = 1'b1;
            end else if (load_out_from_skid) begin
                skid_valid_next = 1'b0;
            end
        end
        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b0;
            out_entry_reg  <= '0;
            skid_entry_reg <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
            if (load_out_from_skid) begin
                out_entry_reg <= skid_entry_reg;
            end else if (load_out_from_in) begin
                out_entry_reg <= dec_entry;
            end
            if (load_skid) begin
                skid_entry_reg <= dec_entry;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_instr   = out_entry_reg.instr;
    assign out_pc      = out_entry_reg.pc;
    assign out_imm     = out_entry_reg.imm;
    assign out_fmt     = out_entry_reg.fmt;
    assign out_target  = out_entry_reg.target;
    assign out_illegal = out_entry_reg.illegal;

endmodule
